// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with registered count, full/empty/almost flags and a one-cycle read strobe.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags with an err_clr input.
module fifo_sync_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                  clka,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wrdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int CW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);
  localparam logic [CW-1:0] AE_LEVEL = CW'(AE_MARGIN);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         w_count_next;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rd_valid;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic                  w_rd_acc;
  logic                  w_wr_acc;

  // A read at full frees a slot in the same edge, so the write may proceed.
  assign w_rd_acc = rd_en & (r_state != ST_EMPTY);
  assign w_wr_acc = wr_en & ((r_state != ST_FULL) | w_rd_acc);

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_next = r_count + CW'(1);
      2'b01:   w_count_next = r_count - CW'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_wr_acc) w_state_next = ST_PARTIAL;
      end
      ST_PARTIAL: begin
        if (w_count_next == DEPTH_C)   w_state_next = ST_FULL;
        else if (w_count_next == '0)   w_state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_rd_acc & ~w_wr_acc) w_state_next = ST_PARTIAL;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clka) begin
    if (!reset_n) begin
      r_state        <= ST_EMPTY;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_almost_full  <= (w_count_next >= AF_LEVEL);
      r_almost_empty <= (w_count_next <= AE_LEVEL);
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + CW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + CW'(1);
    end
  end

  // Storage carries no reset so it maps onto block RAM.
  always_ff @(posedge clka) begin
    if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wrdata;
  end

  always_ff @(posedge clka) begin
    if (!reset_n) begin
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) r_rdata <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  // Clearing takes priority over an error arriving on the same edge.
  always_ff @(posedge clka) begin
    if (!reset_n || err_clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en & ~w_wr_acc) r_overflow  <= 1'b1;
      if (rd_en & ~w_rd_acc) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

  assign rdata        = r_rdata;
  assign rd_valid     = r_rd_valid;
  assign full         = (r_state == ST_FULL);
  assign empty        = (r_state == ST_EMPTY);
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign count        = r_count;

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Single-clock, parametrised successor to the team's FIFO block.
- Generalised in width and depth.
- Adds a registered occupancy count, programmable almost-full/almost-empty thresholds, a read-valid strobe and same-cycle read/write pass-through at full.
- Sits between producer and consumer logic inside one clock domain, where the dual-clock FIFO is overkill.

Parameters:
- DATA_WIDTH, 8, width of wrdata/rdata in bits
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH entries
- AF_MARGIN, 2, almost_full asserts when count >= DEPTH - AF_MARGIN (legal 1..DEPTH-1)
- AE_MARGIN, 2, almost_empty asserts when count <= AE_MARGIN (legal 1..DEPTH-1)

Ports:
- clka  input  1  sole clock, rising edge
- reset_n  input  1  synchronous, active-low reset
- wr_en  input  1  write request
- wrdata  input  DATA_WIDTH  write data, sampled with wr_en
- rd_en  input  1  read request
- rdata  output  DATA_WIDTH  registered read data
- rd_valid  output  1  high for one cycle when rdata carries a newly popped word
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- almost_full  output  1  threshold flag
- almost_empty  output  1  threshold flag
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset: on a clka edge with reset_n=0, the following clear.
  - Pointers and count go to 0; rdata=0; rd_valid=0; full=0; empty=1; almost_full=0; almost_empty=1.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data and any in-flight read, so rd_valid=0 the next cycle.
- Pointers: wr_ptr and rd_ptr are ADDR_WIDTH+1 bits; the low ADDR_WIDTH bits index memory; the MSB is the wrap bit. Both wrap naturally from 2*DEPTH-1 to 0.
- Read accepted: rd_acc = rd_en & !empty.
- Write accepted: wr_acc = wr_en & (!full | rd_acc). At full, a simultaneous read frees the slot and both are accepted.
- At empty with both requested: the read is rejected and the write is accepted. No write-to-read bypass; the word is readable next cycle.
- Requests that are not accepted (write at full without read; read at empty) are ignored silently; pointers, count and memory are unchanged.
- Write: on wr_acc, mem[wr_ptr[ADDR_WIDTH-1:0]] <= wrdata and wr_ptr increments.
- Read latency is 1 cycle. On rd_acc, rdata <= mem[rd_ptr] at that edge, rd_ptr increments, and rd_valid=1 for the following cycle only. Otherwise rdata holds its value and rd_valid=0.
- Count update per edge:
  - +1 on wr_acc & !rd_acc
  - -1 on rd_acc & !wr_acc
  - unchanged when both or neither are accepted
- Flags: all flags are registered and derived from the next-state count, so they are valid in the same cycle as count with no extra lag.
  - full = (count_next == DEPTH)
  - empty = (count_next == 0)
  - almost_full = (count_next >= DEPTH-AF_MARGIN)
  - almost_empty = (count_next <= AE_MARGIN)
- Ordering: strict FIFO order is preserved across pointer wrap.
- Control is a 3-state occupancy FSM: EMPTY, PARTIAL, FULL.
  - EMPTY to PARTIAL on wr_acc.
  - PARTIAL to FULL when count_next == DEPTH.
  - PARTIAL to EMPTY when count_next == 0.
  - FULL to PARTIAL on rd_acc & !wr_acc.
  - full and empty must equal (state==FULL) and (state==EMPTY).

Optional Feature:
- Macro FIFO_ERR_FLAGS_EN.
- When defined, three extra ports are added: input err_clr (1), output overflow (1), output underflow (1).
  - overflow sets sticky on wr_en & !wr_acc.
  - underflow sets sticky on rd_en & !rd_acc.
  - Both clear on reset_n=0 or err_clr=1. If err_clr and a new error occur in the same cycle, clear wins.
- When not defined, these ports and their logic are absent, and rejected requests leave no trace.

Test Plan:
- Reset/empty read: hold reset_n=0 for 4 cycles, release, then pulse rd_en 3 cycles → empty=1, count=0, rd_valid stays 0, rdata=0; with FIFO_ERR_FLAGS_EN, underflow=1.
- Fill to full (DATA_WIDTH=8, ADDR_WIDTH=4, margins 2): write 0x01..0x12 (18 words) back-to-back → count reaches 16 and full=1 after the 16th write; almost_full rises when count=14; writes 0x11, 0x12 are dropped (overflow=1 if enabled).
- Drain and order: from the full state, read 16 times → rdata sequence 0x01..0x10, each with a 1-cycle rd_valid pulse; almost_empty=1 at count=2; empty=1 after the last read.
- Simultaneous read/write at full: with count=16, assert wr_en(0xAA) and rd_en together for one cycle → both accepted, count stays 16, full stays 1, 0xAA is read last after draining.
- Simultaneous at empty, then wrap: at empty, assert wr_en(0x55) and rd_en → only the write is accepted, count=1; then stream 40 interleaved write/read pairs → pointers wrap twice and data order is intact.
- Reset mid-operation: with count=9, drive reset_n=0 for 1 cycle coincident with rd_en → next cycle count=0, empty=1, rd_valid=0, and the next read returns the first word written after reset.
